// File: rtl/sysmgr_mm_pkg.sv
// Shared types and default sizes for the system-manager Avalon-MM master.
package sysmgr_mm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int SYSMGR_ADDR_W      = 11;
    localparam int SYSMGR_DATA_W      = 32;
    localparam int SYSMGR_BE_W        = 4;
    localparam int SYSMGR_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/sysmgr_timeout_ctr.sv
// Per-transaction cycle counter; expire_o is high during the last permitted cycle.
module sysmgr_timeout_ctr #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q == LAST);

    // Holds at LAST so the count can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sysmgr_mm_master.sv
// Single-outstanding Avalon-MM master: one command in, one bus access, one response out.
// Handshake: a transfer on cmd_* or rsp_* happens on a rising edge where valid and ready are both 1.
module sysmgr_mm_master
    import sysmgr_mm_pkg::*;
#(
    parameter int ADDR_W      = SYSMGR_ADDR_W,
    parameter int DATA_W      = SYSMGR_DATA_W,
    parameter int BE_W        = SYSMGR_BE_W,
    parameter int TIMEOUT_CYC = SYSMGR_TIMEOUT_DEF
) (
    input  logic              config_clk_clk,
    input  logic              config_rstn_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    input  logic [BE_W-1:0]   cmd_byteenable,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic              rsp_error,
    output logic              busy,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [ADDR_W-1:0] avm_address,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [BE_W-1:0]   avm_byteenable,
    output logic              avm_read,
    output logic              avm_write,
    output logic              avm_burstcount,
    output logic              avm_debugaccess,
    output state_t            dbg_state_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_error_q, rsp_error_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              stale_q, stale_d;

    logic accept;
    logic expire;
    logic rdv_live;

    assign accept   = (state_q == IDLE) && cmd_valid;
    assign rdv_live = avm_readdatavalid && !stale_q;

    sysmgr_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_i   (config_clk_clk),
        .rst_ni  (config_rstn_reset_n),
        .clr_i   (accept),
        .en_i    ((state_q == ISSUE) || (state_q == WAIT_RD)),
        .expire_o(expire)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        read_d      = read_q;
        write_d     = write_q;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;
        stale_d     = stale_q;

        // A response still owed to an aborted read is swallowed wherever it lands.
        if (avm_readdatavalid && stale_q) begin
            stale_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_address;
                    wdata_d = cmd_writedata;
                    be_d    = cmd_byteenable;
                    read_d  = !cmd_write;
                    write_d = cmd_write;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!avm_waitrequest && write_q) begin
                    write_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else if (!avm_waitrequest && rdv_live) begin
                    read_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = avm_readdata;
                    state_d     = RESP;
                end else if (expire) begin
                    // A read the slave just accepted still owes data, so mark it stale.
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    stale_d     = !avm_waitrequest;
                    state_d     = RESP;
                end else if (!avm_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (rdv_live) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = avm_readdata;
                    state_d     = RESP;
                end else if (expire) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    stale_d     = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge config_clk_clk or negedge config_rstn_reset_n) begin
        if (!config_rstn_reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            stale_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            read_q      <= read_d;
            write_q     <= write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            stale_q     <= stale_d;
        end
    end

    assign cmd_ready       = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign dbg_state_o     = state_q;
    assign avm_address     = addr_q;
    assign avm_writedata   = wdata_q;
    assign avm_byteenable  = be_q;
    assign avm_read        = read_q;
    assign avm_write       = write_q;
    assign avm_burstcount  = 1'b1;
    assign avm_debugaccess = 1'b0;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_error       = rsp_error_q;
    assign rsp_readdata    = rsp_rdata_q;

endmodule
